ps2_cmd_ctrl: RTL
=================

# ps2_cmd_ctrl

Host-to-device command sequencer for the PS/2 keyboard port. It sits beside the PS/2 receiver (the frame decoder that produces 10-bit key values) and shares the open-drain PS2 clock/data lines with it. It accepts a command byte plus an optional argument (e.g. 8'hED + LED mask), runs the PS/2 request-to-send sequence, and shifts the frame out with odd parity. It then checks the line-ack and waits for the device's 8'hFA/8'hFE reply on the receiver's byte stream.

## Interface
Parameters:
- INHIBIT_CYC, 5000: cycles PS2_Clk is held low before request (100 us @ 50 MHz)
- FRAME_TO_CYC, 100000: max cycles from clock release to line-ack (2 ms)
- ACK_TO_CYC, 1000000: max cycles waiting for a reply byte (20 ms)
- MAX_RETRY, 2: resends allowed after 8'hFE

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- PS2_Clk  in  1  raw PS2 clock line (asynchronous)
- PS2_Din  in  1  raw PS2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = drive PS2 clock low; 0 = release
- ps2_dat_oe  out  1  1 = drive PS2 data low; 0 = release
- rx_busy  in  1  receiver mid-frame (bit counter ≠ 0)
- rx_valid  in  1  one-cycle pulse, receiver completed a byte
- rx_byte  in  8  received byte
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_byte  in  8  command
- cmd_has_arg  in  1  send cmd_arg after the command byte is acked
- cmd_arg  in  8  argument byte
- done  out  1  one-cycle pulse, full command acked
- err  out  1  one-cycle pulse, command aborted
- err_code  out  2  0 line-ack missing, 1 frame timeout, 2 reply timeout, 3 resend limit; held until next err

## Operation
- Input sync and falling-edge detection use the same filter as the receiver. Each line passes through a 4-stage shift. A falling edge is the pattern 1,1,0,0 (oldest to newest).
- The command is accepted when cmd_valid && cmd_ready && !rx_busy. cmd_ready is low while rx_busy is high, so the receiver always has priority. cmd_byte, cmd_has_arg and cmd_arg are latched at acceptance.
- States:
  - IDLE: bus released.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYC cycles.
  - REQ: dat_oe = 1 (start bit), clk_oe = 0. Wait for the first falling edge.
  - TX: on falling edges 1–8 drive data bits 0–7, LSB first (dat_oe = ~bit). Edge 9 drives odd parity. Edge 10 releases data (stop).
  - LACK: on edge 11, sample data. 0 goes to WAIT_ACK; 1 is err code 0.
  - WAIT_ACK: 8'hFA with an argument pending sends the argument via INHIBIT, otherwise pulses done and returns to IDLE. 8'hFE resends the current byte via INHIBIT if retries < MAX_RETRY, otherwise err code 3. Any other byte is ignored.
- The retry counter clears when each new byte is started.
- FRAME_TO_CYC counts from leaving INHIBIT to reaching LACK. Expiry gives err code 1. ACK_TO_CYC expiry in WAIT_ACK gives err code 2.
- Every error releases both lines in the same cycle, drops any pending argument and returns to IDLE.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_dat_oe = 0, cmd_ready = 1 (IDLE), done = 0, err = 0, err_code = 0, FSM = IDLE, counters = 0.
- Reset asserted mid-frame releases both lines on the next clk edge. The partial frame is abandoned.
- Edge detection lags the pin by 3 clk. The data change therefore occurs ≤ 4 clk after the physical falling edge, well inside the device's low phase.
- The cycle after acceptance, the block enters INHIBIT with clk_oe = 1.
- After INHIBIT_CYC cycles, REQ drives data low for 1 cycle before releasing the clock.
- done or err asserts exactly 1 cycle after the deciding rx_valid, sample or timeout. cmd_ready returns in the following cycle.
- Falling edges seen in IDLE are ignored. rx_valid outside WAIT_ACK is ignored.

## Configuration
- PS2_CMD_RETRY_EN defined: 8'hFE triggers up to MAX_RETRY resends as above.
- Not defined: 8'hFE immediately raises err code 3. No retry counter is built, and MAX_RETRY is unused.

## Structure
- Shared package ps2_pkg holds:
  - FSM state enum.
  - Reply constants ACK 8'hFA, RESEND 8'hFE, BAT 8'hAA.
  - Command constants SET_LED 8'hED, RESET 8'hFF.
  - Error-code localparams.
- One sub-module: ps2_edge_sync (4-stage synchronizer plus falling-edge pulse). It is reused by the receiver.

## Test plan
- Send 8'hFF, no argument. The device model clocks 11 edges, line-acks, then returns 8'hFA → observed bits 1,1,1,1,1,1,1,1, parity 1; done pulses once.
- Send 8'hED with argument 8'h07, both acked → second frame bits 1,1,1,0,0,0,0,0, parity 0; a single done after the second 8'hFA.
- Reply 8'hFE twice then 8'hFA, with RETRY_EN → three identical frames, then done. Reply 8'hFE three times → err, err_code = 3. Without RETRY_EN, the first 8'hFE → err_code = 3.
- Device stops clocking after edge 5 → err with err_code = 1, FRAME_TO_CYC cycles after leaving INHIBIT; both oe = 0.
- cmd_valid while rx_busy = 1 → cmd_ready = 0 and no oe activity until rx_busy = 0, then INHIBIT begins the next cycle.
- rst_n low during TX edge 6 → both oe = 0 and cmd_ready = 1 after one clk. The next command completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host command path:
//                sequencer state encoding, device reply codes, host command
//                codes, error codes and the odd-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    // Command sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_TX       = 3'd3,
        ST_LACK     = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_e;

    // Device reply bytes
    localparam logic [7:0] ACK     = 8'hFA;
    localparam logic [7:0] RESEND  = 8'hFE;
    localparam logic [7:0] BAT     = 8'hAA;

    // Host command bytes
    localparam logic [7:0] SET_LED = 8'hED;
    localparam logic [7:0] RESET   = 8'hFF;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_LINE_ACK = 2'd0;
    localparam logic [1:0] ERR_FRAME_TO = 2'd1;
    localparam logic [1:0] ERR_REPLY_TO = 2'd2;
    localparam logic [1:0] ERR_RESEND   = 2'd3;

    // Parity bit that makes the 9-bit word (data + parity) have odd weight
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_cmd_ctrl_if.sv
// ============================================================================
//  Module      : ps2_cmd_ctrl_if
//  Description : Command handshake and receiver byte-stream bundle for the
//                PS/2 command sequencer. master = host/receiver side,
//                slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       rx_busy;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        output rx_busy, rx_valid, rx_byte,
        input  cmd_ready, done, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        input  rx_busy, rx_valid, rx_byte,
        output cmd_ready, done, err, err_code
    );
endinterface

`default_nettype wire

// File: rtl/ps2_edge_sync.sv
// ============================================================================
//  Module      : ps2_edge_sync
//  Description : 4-stage synchronizer for one raw PS/2 line with a
//                falling-edge pulse (pattern 1,1,0,0 oldest to newest).
//                Shared with the PS/2 receiver so both see identical edges.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_edge_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic line_i,
    output logic      level_o,
    output logic      fall_o
);

    logic [3:0] sh_q;

    // Shift the raw line in; reset to the idle-high level so no false edge
    always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= 4'b1111;
        else        sh_q <= {sh_q[2:0], line_i};
    end

    assign fall_o  = (sh_q == 4'b1100);
    // Level taken from the stage that just confirmed a low on a fall
    assign level_o = sh_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_cmd_ctrl.sv
// ============================================================================
//  Module      : ps2_cmd_ctrl
//  Description : PS/2 host-to-device command sequencer. Inhibits the clock,
//                issues request-to-send, shifts out a byte with odd parity,
//                checks the line-ack and waits for the 8'hFA / 8'hFE reply.
//                Optional argument byte is sent after the command is acked.
//  Config      : PS2_CMD_RETRY_EN - when defined, 8'hFE causes up to
//                MAX_RETRY resends; otherwise 8'hFE aborts with code 3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 5000,
    parameter int FRAME_TO_CYC = 100000,
    parameter int ACK_TO_CYC   = 1000000,
    parameter int MAX_RETRY    = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       PS2_Clk,
    input  wire logic       PS2_Din,
    output logic            ps2_clk_oe,
    output logic            ps2_dat_oe,
    ps2_cmd_ctrl_if.slave   bus
);

    localparam int MAX_A   = (INHIBIT_CYC > FRAME_TO_CYC) ? INHIBIT_CYC : FRAME_TO_CYC;
    localparam int MAX_CYC = (MAX_A > ACK_TO_CYC) ? MAX_A : ACK_TO_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] FTO_LAST = CNT_W'(FRAME_TO_CYC - 1);
    localparam logic [CNT_W-1:0] ATO_LAST = CNT_W'(ACK_TO_CYC - 1);

    logic w_clk_lvl, w_clk_fall;
    logic w_dat_lvl, w_dat_fall;
    logic w_unused_lines;

    ps2_edge_sync u_clk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (PS2_Clk),
        .level_o (w_clk_lvl),
        .fall_o  (w_clk_fall)
    );

    ps2_edge_sync u_dat_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (PS2_Din),
        .level_o (w_dat_lvl),
        .fall_o  (w_dat_fall)
    );

    // Outputs of the shared synchronizer this block does not need
    assign w_unused_lines = &{1'b0, w_clk_lvl, w_dat_fall, (MAX_RETRY > 0)};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       byte_q;
    logic [7:0]       arg_q;
    logic             arg_pend_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;

`ifdef PS2_CMD_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q;
`endif

    // The frame timer covers REQ through the line-ack so a device that stops
    // clocking anywhere in the frame cannot hang the sequencer.
    logic w_frame_to;
    assign w_frame_to = (cnt_q == FTO_LAST);

    // Sequencer: state, timers, frame shifting and registered line/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            arg_q      <= '0;
            arg_pend_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_LINE_ACK;
`ifdef PS2_CMD_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        byte_q     <= bus.cmd_byte;
                        arg_q      <= bus.cmd_arg;
                        arg_pend_q <= bus.cmd_has_arg;
`ifdef PS2_CMD_RETRY_EN
                        retry_q    <= '0;
`endif
                        cnt_q      <= '0;
                        clk_oe_q   <= 1'b1;
                        state_q    <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q    <= '0;
                        dat_oe_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_REQ, ST_TX, ST_LACK: begin
                    if (w_frame_to) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_FRAME_TO;
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        arg_pend_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (state_q == ST_REQ) begin
                            // Start bit held one cycle with the clock still low
                            if (clk_oe_q) begin
                                clk_oe_q <= 1'b0;
                            end else if (w_clk_fall) begin
                                dat_oe_q  <= ~byte_q[0];
                                bit_cnt_q <= 4'd1;
                                state_q   <= ST_TX;
                            end
                        end else if (state_q == ST_TX) begin
                            if (w_clk_fall) begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                if (bit_cnt_q < 4'd8) begin
                                    dat_oe_q <= ~byte_q[bit_cnt_q[2:0]];
                                end else if (bit_cnt_q == 4'd8) begin
                                    dat_oe_q <= ~odd_parity(byte_q);
                                end else begin
                                    dat_oe_q <= 1'b0;
                                    state_q  <= ST_LACK;
                                end
                            end
                        end else begin
                            if (w_clk_fall) begin
                                if (!w_dat_lvl) begin
                                    cnt_q   <= '0;
                                    state_q <= ST_WAIT_ACK;
                                end else begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_LINE_ACK;
                                    clk_oe_q   <= 1'b0;
                                    dat_oe_q   <= 1'b0;
                                    arg_pend_q <= 1'b0;
                                    cnt_q      <= '0;
                                    state_q    <= ST_IDLE;
                                end
                            end
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    if (bus.rx_valid && (bus.rx_byte == ACK)) begin
                        cnt_q <= '0;
                        if (arg_pend_q) begin
                            byte_q     <= arg_q;
                            arg_pend_q <= 1'b0;
`ifdef PS2_CMD_RETRY_EN
                            retry_q    <= '0;
`endif
                            clk_oe_q   <= 1'b1;
                            state_q    <= ST_INHIBIT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if (bus.rx_valid && (bus.rx_byte == RESEND)) begin
                        cnt_q <= '0;
`ifdef PS2_CMD_RETRY_EN
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_q  <= retry_q + 1'b1;
                            clk_oe_q <= 1'b1;
                            state_q  <= ST_INHIBIT;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RESEND;
                            clk_oe_q   <= 1'b0;
                            dat_oe_q   <= 1'b0;
                            arg_pend_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
`else
                        err_q      <= 1'b1;
                        err_code_q <= ERR_RESEND;
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        arg_pend_q <= 1'b0;
                        state_q    <= ST_IDLE;
`endif
                    end else if (cnt_q == ATO_LAST) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_REPLY_TO;
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        arg_pend_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_dat_oe    = dat_oe_q;
    assign bus.cmd_ready = (state_q == ST_IDLE) && !bus.rx_busy;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule

`default_nettype wire
